fpu_cvt_sched: RTL and testbench
================================

Name: fpu_cvt_sched

Overview:
- Scheduler that shares the single FP-to-integer convert unit (cvt_FP_I_mod) between the three FPU lanes (fpu0/1/2) of the low FPU cluster.
- Accepts at most one convert request per cycle using round-robin arbitration.
- Drives the converter's enable, operand and format controls, and tracks in-flight ops through a stall-aware shadow pipeline.
- Returns each result with its lane and return tag to the writeback path.

Parameters:
- NLANE, 3, number of requesting FPU lanes (fixed 3; lane id 2 bits).
- CVT_LAT, 2, converter latency in enabled cycles from en to valid res.
- TAGW, 14, width of return tag (matches u*_ret).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  global FP retire stall (fxFRT_alten_reg3 class); freezes the block and the converter.
- rq_vld  in  3  per-lane request valid.
- rq_rdy  out  3  per-lane accept; transfer on vld&rdy.
- rq_op  in  24  per-lane 8-bit op code (lane i at [8i+7:8i]).
- rq_data  in  204  per-lane 68-bit operand, low 66 bits significant.
- rq_hi  in  48  per-lane 16-bit extended-precision high part.
- rq_tag  in  42  per-lane return tag.
- cvt_en  out  1  converter enable.
- cvt_clkEn  out  1  converter clock enable = ~stall.
- cvt_A  out  82  converter operand.
- cvt_isDBL, cvt_isEXT, cvt_isSNG, cvt_verbatim, cvt_is32b  out  1 each  format controls.
- cvt_res  in  65  converter result.
- cvt_alt  in  1  converter alternate/exception flag.
- res_vld  out  1  result valid (single-cycle pulse).
- res_data  out  65  result.
- res_alt  out  1  exception/illegal flag.
- res_lane  out  2  originating lane.
- res_tag  out  TAGW  originating tag.
- busy  out  1  any op in issue stage or shadow pipe.

Behaviour:
- Reset: all outputs 0 (cvt_clkEn follows ~stall); RR pointer = lane 0 highest priority; shadow pipe cleared. Reset mid-operation discards in-flight ops with no res_vld.
- Legal ops are `fop_cvtD, `fop_cvtE, `fop_cvtS, `fop_cvt32S, `fop_cvt32D and `fop_tblD.
- rq_rdy[i] = ~stall & (grant==i). Grant goes to the first lane with rq_vld, starting at the RR pointer. The pointer moves to grant+1 (mod 3) only on an accepted transfer.
- Accept cycle t registers the issue stage. cvt_en is high in cycle t+1 for legal ops.
- Operand at t+1:
  - DBL/32D/EXT: cvt_A = {hi,data[65:0]}.
  - Otherwise: cvt_A = {16'b0,data[65:0]}.
- Format controls at t+1:
  - isDBL = cvtD|cvt32D.
  - isEXT = cvtE.
  - isSNG = ~(isDBL|isEXT).
  - verbatim = tblD.
  - is32b = cvt32S|cvt32D.
- Illegal op: accepted; cvt_en stays 0; it travels the shadow pipe. It returns with res_alt=1 and res_data=0 at the same latency.
- Shadow pipe: CVT_LAT entries of {vld,lane,tag,illegal}, advancing only when ~stall.
- res_vld is asserted at t+1+CVT_LAT enabled cycles.
  - res_data and res_alt are sampled from cvt_res/cvt_alt when legal.
  - Outputs are registered and held one cycle only; there is no downstream backpressure.
- Stall: rq_rdy=0, and issue stage, pipe, RR pointer and res regs are all frozen. A res_vld pulse that was already asserted is not repeated: res_vld drops to 0 while stalled.
- Throughput: one op per enabled cycle; back-to-back accepts are legal.
- Simultaneous accept and retire in the same cycle is normal pipelined operation.
- busy = issue-stage vld | any pipe vld.

Decomposition:
- Use the existing fpoperations.sv `fop_* constants.
- Put a shared package entry for the cvt_sched_ent_t struct {vld, lane[1:0], tag[TAGW-1:0], illegal}, plus the localparam NLANE.
- One sub-module: rr_arb3 (combinational 3-way round-robin pick plus registered pointer update).

Test Plan:
- Single op: lane1 cvtS, data=0x3F800000, tag=0x123, CVT_LAT=2; accepted cycle 0 → cvt_en cycle 1 with isSNG=1 and cvt_A[81:66]=0 → res_vld cycle 3, lane=1, tag=0x123, data=model.
- Round-robin: all three lanes hold vld from reset → grants 0,1,2,0 on consecutive cycles; 4 res pulses in order, lane ids 0,1,2,0.
- Stall mid-flight: accept at cycle 0, stall cycles 1-3 → rq_rdy=0 during stall, cvt_clkEn=0, res_vld at cycle 6, no duplicate pulse.
- Illegal op (fop_add) on lane2, tag=0x7 → no cvt_en; res_vld after 1+CVT_LAT cycles with res_alt=1, res_data=0, lane=2.
- Ext/32 formats: lane0 cvtE with hi=0xBEEF → cvt_A[81:66]=0xBEEF and isEXT=1; lane0 cvt32D → isDBL=1 and is32b=1.
- Reset during flight: 2 ops in pipe, rst for 1 cycle → no res_vld afterwards, busy=0, next grant goes to lane 0.

Source files
------------

// File: rtl/fpu_cvt_sched_pkg.sv
// Shared types and constants for the low-cluster FP-to-integer convert scheduler.
// Op codes mirror the `fop_* values of fpoperations.sv.
package fpu_cvt_sched_pkg;

    localparam int unsigned NLANE       = 3;
    localparam int unsigned CVT_LAT_DEF = 2;
    localparam int unsigned TAGW        = 14;

    localparam logic [7:0] FOP_ADD    = 8'h01;
    localparam logic [7:0] FOP_CVTD   = 8'h30;
    localparam logic [7:0] FOP_CVTE   = 8'h31;
    localparam logic [7:0] FOP_CVTS   = 8'h32;
    localparam logic [7:0] FOP_CVT32S = 8'h33;
    localparam logic [7:0] FOP_CVT32D = 8'h34;
    localparam logic [7:0] FOP_TBLD   = 8'h35;

    typedef struct packed {
        logic            vld;
        logic [1:0]      lane;
        logic [TAGW-1:0] tag;
        logic            illegal;
    } cvt_sched_ent_t;

    function automatic logic fop_is_cvt(input logic [7:0] op);
        return (op == FOP_CVTD)   || (op == FOP_CVTE)   || (op == FOP_CVTS) ||
               (op == FOP_CVT32S) || (op == FOP_CVT32D) || (op == FOP_TBLD);
    endfunction

    function automatic logic [1:0] lane_inc(input logic [1:0] l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin pick; the pointer advances past the winner only on an accepted transfer.
module rr_arb3
    import fpu_cvt_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       adv,
    output logic [1:0] grant,
    output logic       gnt_vld
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] l0, l1, l2;

    always_comb begin
        l0      = ptr_q;
        l1      = lane_inc(l0);
        l2      = lane_inc(l1);
        grant   = ptr_q;
        gnt_vld = 1'b0;
        if (req[l0]) begin
            grant   = l0;
            gnt_vld = 1'b1;
        end else if (req[l1]) begin
            grant   = l1;
            gnt_vld = 1'b1;
        end else if (req[l2]) begin
            grant   = l2;
            gnt_vld = 1'b1;
        end
        ptr_d = adv ? lane_inc(grant) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fpu_cvt_sched.sv
// Shares the single FP-to-integer converter between the three low-cluster FPU lanes and
// tracks in-flight ops in a stall-aware shadow pipe that returns lane and tag with each result.
module fpu_cvt_sched
    import fpu_cvt_sched_pkg::*;
#(
    parameter int unsigned CVT_LAT = CVT_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [NLANE-1:0]       rq_vld,
    output logic [NLANE-1:0]       rq_rdy,
    input  logic [8*NLANE-1:0]     rq_op,
    input  logic [68*NLANE-1:0]    rq_data,
    input  logic [16*NLANE-1:0]    rq_hi,
    input  logic [TAGW*NLANE-1:0]  rq_tag,
    output logic                   cvt_en,
    output logic                   cvt_clkEn,
    output logic [81:0]            cvt_A,
    output logic                   cvt_isDBL,
    output logic                   cvt_isEXT,
    output logic                   cvt_isSNG,
    output logic                   cvt_verbatim,
    output logic                   cvt_is32b,
    input  logic [64:0]            cvt_res,
    input  logic                   cvt_alt,
    output logic                   res_vld,
    output logic [64:0]            res_data,
    output logic                   res_alt,
    output logic [1:0]             res_lane,
    output logic [TAGW-1:0]        res_tag,
    output logic                   busy
);

    logic [1:0] grant;
    logic       gnt_vld;
    logic       accept;

    rr_arb3 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rq_vld),
        .adv     (accept),
        .grant   (grant),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        accept = gnt_vld & ~stall;
        rq_rdy = '0;
        if (accept) rq_rdy[grant] = 1'b1;
    end

    logic            iss_vld_q,  iss_vld_d;
    logic [1:0]      iss_lane_q, iss_lane_d;
    logic [TAGW-1:0] iss_tag_q,  iss_tag_d;
    logic [7:0]      iss_op_q,   iss_op_d;
    logic [65:0]     iss_data_q, iss_data_d;
    logic [15:0]     iss_hi_q,   iss_hi_d;

    always_comb begin
        iss_vld_d  = iss_vld_q;
        iss_lane_d = iss_lane_q;
        iss_tag_d  = iss_tag_q;
        iss_op_d   = iss_op_q;
        iss_data_d = iss_data_q;
        iss_hi_d   = iss_hi_q;
        if (!stall) begin
            iss_vld_d = accept;
            if (accept) begin
                iss_lane_d = grant;
                iss_tag_d  = rq_tag[int'(grant)*TAGW +: TAGW];
                iss_op_d   = rq_op[int'(grant)*8 +: 8];
                iss_data_d = rq_data[int'(grant)*68 +: 66];
                iss_hi_d   = rq_hi[int'(grant)*16 +: 16];
            end
        end
    end

    logic legal, is_dbl, is_ext, wide;

    always_comb begin
        legal        = fop_is_cvt(iss_op_q);
        is_dbl       = (iss_op_q == FOP_CVTD) || (iss_op_q == FOP_CVT32D);
        is_ext       = (iss_op_q == FOP_CVTE);
        wide         = is_dbl | is_ext;
        cvt_en       = iss_vld_q & legal;
        cvt_clkEn    = ~stall;
        cvt_A        = cvt_en ? {(wide ? iss_hi_q : 16'h0000), iss_data_q} : '0;
        cvt_isDBL    = cvt_en & is_dbl;
        cvt_isEXT    = cvt_en & is_ext;
        cvt_isSNG    = cvt_en & ~wide;
        cvt_verbatim = cvt_en & (iss_op_q == FOP_TBLD);
        cvt_is32b    = cvt_en & ((iss_op_q == FOP_CVT32S) || (iss_op_q == FOP_CVT32D));
    end

    // The result register acts as the final shadow stage, so the pipe holds CVT_LAT-1 entries.
    cvt_sched_ent_t pipe_q [CVT_LAT-1];
    cvt_sched_ent_t pipe_d [CVT_LAT-1];
    cvt_sched_ent_t last_ent;

    always_comb begin
        pipe_d = pipe_q;
        if (!stall) begin
            pipe_d[0].vld     = iss_vld_q;
            pipe_d[0].lane    = iss_lane_q;
            pipe_d[0].tag     = iss_tag_q;
            pipe_d[0].illegal = ~legal;
            for (int unsigned k = 1; k < CVT_LAT - 1; k++) pipe_d[k] = pipe_q[k-1];
        end
        last_ent = pipe_q[CVT_LAT-2];
    end

    logic            res_vld_q,  res_vld_d;
    logic [64:0]     res_data_q, res_data_d;
    logic            res_alt_q,  res_alt_d;
    logic [1:0]      res_lane_q, res_lane_d;
    logic [TAGW-1:0] res_tag_q,  res_tag_d;

    // A stall drops a pulse already shown; the entry it came from has already left the pipe.
    always_comb begin
        res_vld_d  = 1'b0;
        res_data_d = res_data_q;
        res_alt_d  = res_alt_q;
        res_lane_d = res_lane_q;
        res_tag_d  = res_tag_q;
        if (!stall && last_ent.vld) begin
            res_vld_d  = 1'b1;
            res_lane_d = last_ent.lane;
            res_tag_d  = last_ent.tag;
            res_data_d = last_ent.illegal ? '0 : cvt_res;
            res_alt_d  = last_ent.illegal | cvt_alt;
        end
    end

    always_comb begin
        res_vld  = res_vld_q;
        res_data = res_data_q;
        res_alt  = res_alt_q;
        res_lane = res_lane_q;
        res_tag  = res_tag_q;
        busy     = iss_vld_q;
        for (int unsigned k = 0; k < CVT_LAT - 1; k++) busy = busy | pipe_q[k].vld;
    end

    logic unused_ok;
    assign unused_ok = ^{rq_data[67:66], rq_data[135:134], rq_data[203:202]};

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld_q  <= 1'b0;
            iss_lane_q <= '0;
            iss_tag_q  <= '0;
            iss_op_q   <= '0;
            iss_data_q <= '0;
            iss_hi_q   <= '0;
            for (int unsigned k = 0; k < CVT_LAT - 1; k++) pipe_q[k] <= '0;
            res_vld_q  <= 1'b0;
            res_data_q <= '0;
            res_alt_q  <= 1'b0;
            res_lane_q <= '0;
            res_tag_q  <= '0;
        end else begin
            iss_vld_q  <= iss_vld_d;
            iss_lane_q <= iss_lane_d;
            iss_tag_q  <= iss_tag_d;
            iss_op_q   <= iss_op_d;
            iss_data_q <= iss_data_d;
            iss_hi_q   <= iss_hi_d;
            pipe_q     <= pipe_d;
            res_vld_q  <= res_vld_d;
            res_data_q <= res_data_d;
            res_alt_q  <= res_alt_d;
            res_lane_q <= res_lane_d;
            res_tag_q  <= res_tag_d;
        end
    end

endmodule

// File: tb/tb_fpu_cvt_sched.sv
// Directed bench for fpu_cvt_sched; a one-stage converter stand-in returns A[64:0]+7, alt=A[0].
module tb_fpu_cvt_sched;
  import fpu_cvt_sched_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic [2:0]   rq_vld;
  logic [2:0]   rq_rdy;
  logic [23:0]  rq_op;
  logic [203:0] rq_data;
  logic [47:0]  rq_hi;
  logic [41:0]  rq_tag;
  logic         cvt_en, cvt_clkEn;
  logic [81:0]  cvt_A;
  logic         cvt_isDBL, cvt_isEXT, cvt_isSNG, cvt_verbatim, cvt_is32b;
  logic [64:0]  cvt_res;
  logic         cvt_alt;
  logic         res_vld;
  logic [64:0]  res_data;
  logic         res_alt;
  logic [1:0]   res_lane;
  logic [13:0]  res_tag;
  logic         busy;

  int checks = 0;
  int errors = 0;

  fpu_cvt_sched #(.CVT_LAT(2)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rq_vld(rq_vld), .rq_rdy(rq_rdy), .rq_op(rq_op), .rq_data(rq_data),
    .rq_hi(rq_hi), .rq_tag(rq_tag),
    .cvt_en(cvt_en), .cvt_clkEn(cvt_clkEn), .cvt_A(cvt_A),
    .cvt_isDBL(cvt_isDBL), .cvt_isEXT(cvt_isEXT), .cvt_isSNG(cvt_isSNG),
    .cvt_verbatim(cvt_verbatim), .cvt_is32b(cvt_is32b),
    .cvt_res(cvt_res), .cvt_alt(cvt_alt),
    .res_vld(res_vld), .res_data(res_data), .res_alt(res_alt),
    .res_lane(res_lane), .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [64:0] conv_q = '0;
  logic        conv_alt_q = 1'b0;
  always @(posedge clk) begin
    if (cvt_clkEn && cvt_en) begin
      conv_q     <= cvt_A[64:0] + 65'd7;
      conv_alt_q <= cvt_A[0];
    end
  end
  assign cvt_res = conv_q;
  assign cvt_alt = conv_alt_q;

  task automatic chk(input string nm, input logic [81:0] obs, input logic [81:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] op, input logic [65:0] d,
                          input logic [15:0] h, input logic [13:0] t);
    rq_op[8*i +: 8]     = op;
    rq_data[68*i +: 68] = {2'b00, d};
    rq_hi[16*i +: 16]   = h;
    rq_tag[14*i +: 14]  = t;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rq_vld = '0;
    rq_op = '0; rq_data = '0; rq_hi = '0; rq_tag = '0;
    tick(); tick();
    chk("rst_res_vld", res_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cvt_en", cvt_en, 1'b0);
    chk("rst_clken", cvt_clkEn, 1'b1);
    chk("rst_cvt_A", cvt_A, 82'h0);
    chk("rst_rdy", rq_rdy, 3'b000);
    rst = 1'b0;
    tick();

    set_lane(1, FOP_CVTS, 66'h3F800000, 16'hAAAA, 14'h123);
    rq_vld = 3'b010; #1;
    chk("s_rdy", rq_rdy, 3'b010);
    tick(); rq_vld = '0; #1;
    chk("s_en", cvt_en, 1'b1);
    chk("s_sng", cvt_isSNG, 1'b1);
    chk("s_A_hi", cvt_A[81:66], 16'h0000);
    chk("s_A_lo", cvt_A[65:0], 66'h3F800000);
    chk("s_vld_c1", res_vld, 1'b0);
    tick();
    chk("s_vld_c2", res_vld, 1'b0);
    tick();
    chk("s_vld_c3", res_vld, 1'b1);
    chk("s_lane", res_lane, 2'd1);
    chk("s_tag", res_tag, 14'h123);
    chk("s_data", res_data, 65'h3F800007);
    chk("s_alt", res_alt, 1'b0);
    tick();
    chk("s_vld_c4", res_vld, 1'b0);
    chk("s_busy_c4", busy, 1'b0);

    set_lane(2, FOP_ADD, 66'hFF, 16'h0, 14'h7);
    rq_vld = 3'b100; #1;
    chk("i_rdy", rq_rdy, 3'b100);
    tick(); rq_vld = '0; #1;
    chk("i_en", cvt_en, 1'b0);
    chk("i_busy", busy, 1'b1);
    tick();
    chk("i_vld_c2", res_vld, 1'b0);
    tick();
    chk("i_vld_c3", res_vld, 1'b1);
    chk("i_alt", res_alt, 1'b1);
    chk("i_data", res_data, 65'h0);
    chk("i_lane", res_lane, 2'd2);
    chk("i_tag", res_tag, 14'h7);
    stall = 1'b1;
    tick();
    chk("i_vld_stall", res_vld, 1'b0);
    stall = 1'b0;
    tick();
    chk("i_no_repeat", res_vld, 1'b0);
    chk("i_busy_end", busy, 1'b0);

    set_lane(0, FOP_CVTE, 66'h10, 16'hBEEF, 14'h31);
    rq_vld = 3'b001; #1;
    chk("f_rdy", rq_rdy, 3'b001);
    tick();
    chk("f_e_hi", cvt_A[81:66], 16'hBEEF);
    chk("f_e_lo", cvt_A[65:0], 66'h10);
    chk("f_e_ext", cvt_isEXT, 1'b1);
    chk("f_e_dbl", cvt_isDBL, 1'b0);
    chk("f_e_sng", cvt_isSNG, 1'b0);
    chk("f_e_32", cvt_is32b, 1'b0);
    set_lane(0, FOP_CVT32D, 66'h20, 16'h0042, 14'h32);
    tick();
    chk("f_d_dbl", cvt_isDBL, 1'b1);
    chk("f_d_32", cvt_is32b, 1'b1);
    chk("f_d_ext", cvt_isEXT, 1'b0);
    chk("f_d_hi", cvt_A[81:66], 16'h0042);
    set_lane(0, FOP_TBLD, 66'h30, 16'h7777, 14'h33);
    tick(); rq_vld = '0; #1;
    chk("f_t_verb", cvt_verbatim, 1'b1);
    chk("f_t_sng", cvt_isSNG, 1'b1);
    chk("f_t_hi", cvt_A[81:66], 16'h0000);
    chk("f_r1_vld", res_vld, 1'b1);
    chk("f_r1_data", res_data, 65'h17);
    chk("f_r1_tag", res_tag, 14'h31);
    tick();
    chk("f_r2_data", res_data, 65'h27);
    chk("f_r2_tag", res_tag, 14'h32);
    tick();
    chk("f_r3_data", res_data, 65'h37);
    chk("f_r3_tag", res_tag, 14'h33);
    tick();
    chk("f_end_vld", res_vld, 1'b0);

    set_lane(0, FOP_CVTD, 66'h5, 16'h1234, 14'h55);
    rq_vld = 3'b001; #1;
    chk("st_rdy0", rq_rdy, 3'b001);
    tick();
    stall = 1'b1;
    set_lane(2, FOP_CVTS, 66'h9, 16'h0, 14'h66);
    rq_vld = 3'b100; #1;
    chk("st_rdy1", rq_rdy, 3'b000);
    chk("st_clken", cvt_clkEn, 1'b0);
    chk("st_en", cvt_en, 1'b1);
    chk("st_dbl", cvt_isDBL, 1'b1);
    chk("st_A_hi", cvt_A[81:66], 16'h1234);
    chk("st_vld1", res_vld, 1'b0);
    tick();
    chk("st_vld2", res_vld, 1'b0);
    chk("st_busy2", busy, 1'b1);
    tick();
    chk("st_rdy3", rq_rdy, 3'b000);
    chk("st_vld3", res_vld, 1'b0);
    tick();
    stall = 1'b0; rq_vld = '0; #1;
    chk("st_clken4", cvt_clkEn, 1'b1);
    chk("st_vld4", res_vld, 1'b0);
    tick();
    chk("st_vld5", res_vld, 1'b0);
    tick();
    chk("st_vld6", res_vld, 1'b1);
    chk("st_data6", res_data, 65'hC);
    chk("st_alt6", res_alt, 1'b1);
    chk("st_lane6", res_lane, 2'd0);
    chk("st_tag6", res_tag, 14'h55);
    tick();
    chk("st_vld7", res_vld, 1'b0);

    set_lane(1, FOP_CVTS, 66'h40, 16'h0, 14'h21);
    rq_vld = 3'b010; #1;
    chk("r_rdy0", rq_rdy, 3'b010);
    tick();
    set_lane(1, FOP_CVTS, 66'h41, 16'h0, 14'h22); #1;
    chk("r_rdy1", rq_rdy, 3'b010);
    tick();
    rq_vld = '0; rst = 1'b1; #1;
    chk("r_busy_pre", busy, 1'b1);
    tick();
    rst = 1'b0; #1;
    chk("r_busy", busy, 1'b0);
    chk("r_vld3", res_vld, 1'b0);
    chk("r_en", cvt_en, 1'b0);
    tick();
    chk("r_vld4", res_vld, 1'b0);
    tick();
    chk("r_vld5", res_vld, 1'b0);

    set_lane(0, FOP_CVTS, 66'h1, 16'h0, 14'hA);
    set_lane(1, FOP_CVTS, 66'h2, 16'h0, 14'hB);
    set_lane(2, FOP_CVTS, 66'h3, 16'h0, 14'hC);
    rq_vld = 3'b111; #1;
    chk("rr_g0", rq_rdy, 3'b001);
    tick();
    chk("rr_g1", rq_rdy, 3'b010);
    tick();
    chk("rr_g2", rq_rdy, 3'b100);
    tick();
    chk("rr_g3", rq_rdy, 3'b001);
    chk("rr_r0_vld", res_vld, 1'b1);
    chk("rr_r0_lane", res_lane, 2'd0);
    chk("rr_r0_tag", res_tag, 14'hA);
    chk("rr_r0_data", res_data, 65'h8);
    tick();
    rq_vld = '0; #1;
    chk("rr_rdy_idle", rq_rdy, 3'b000);
    chk("rr_r1_lane", res_lane, 2'd1);
    chk("rr_r1_data", res_data, 65'h9);
    tick();
    chk("rr_r2_lane", res_lane, 2'd2);
    chk("rr_r2_tag", res_tag, 14'hC);
    chk("rr_r2_data", res_data, 65'hA);
    tick();
    chk("rr_r3_vld", res_vld, 1'b1);
    chk("rr_r3_lane", res_lane, 2'd0);
    tick();
    chk("rr_end_vld", res_vld, 1'b0);
    chk("rr_end_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
